// File: rtl/prbs_pkg.sv
// Shared types and helpers for the ITU O.150 PRBS generator and checker.
// Holds the checker state encoding, the supported polynomial table and a popcount.
package prbs_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLock
    } prbs_state_e;

    // Supported (length, tap) pairs; PRBS20 is listed with both of its usual taps.
    localparam int unsigned PolyNum = 8;
    localparam int unsigned PolyLen [PolyNum] = '{9, 11, 15, 20, 20, 23, 29, 31};
    localparam int unsigned PolyTap [PolyNum] = '{5, 9, 14, 3, 17, 18, 27, 28};

    localparam int unsigned PopMaxW = 1024;

    function automatic bit poly_valid(input int unsigned len, input int unsigned tap);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < int'(PolyNum); i++) begin
            if (PolyLen[i] == len && PolyTap[i] == tap) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic int unsigned popcount(input logic [PopMaxW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(PopMaxW); i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_itu_o150.sv
// Combinational ITU O.150 parallel PRBS generator: one DATW-bit word per call, MSB first,
// plus the LFSR state that follows the word.
module prbs_itu_o150 #(
    parameter int unsigned DATW = 64,
    parameter int unsigned STA0 = 9,
    parameter int unsigned STA1 = 5
) (
    input  logic [STA0-1:0] iprbs_cur,
    output logic [STA0-1:0] oprbs_nxt,
    output logic [DATW-1:0] oprbs_dat
);

    logic [STA0-1:0] s;

    always_comb begin
        s         = iprbs_cur;
        oprbs_dat = '0;
        for (int i = int'(DATW) - 1; i >= 0; i--) begin
            oprbs_dat[i] = s[STA0-1] ^ s[STA1-1];
            s            = {s[STA0-2:0], oprbs_dat[i]};
        end
        oprbs_nxt = s;
    end

endmodule

// File: rtl/prbs_chk_o150.sv
// ITU O.150 PRBS checker: hunts for a seed, verifies LOCK_CNT clean words, then counts
// bit errors against a free-running local generator until LOSS_CNT errored words in a row.
module prbs_chk_o150
    import prbs_pkg::*;
#(
    parameter int unsigned DATW     = 64,
    parameter int unsigned STA0     = 9,
    parameter int unsigned STA1     = 5,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned ERRW     = 32
) (
    input  logic                      iclk,
    input  logic                      irst,
    input  logic                      ivld,
    input  logic [DATW-1:0]           idat,
    input  logic                      iclr,
    output logic                      olock,
    output logic                      oerr,
    output logic [$clog2(DATW+1)-1:0] oerr_nbit,
    output logic [ERRW-1:0]           oerr_cnt
);

    localparam int unsigned NBW  = $clog2(DATW + 1);
    localparam int unsigned GW   = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW   = $clog2(LOSS_CNT + 1);
    localparam int unsigned SumW = ERRW + NBW;
    localparam bit ParamOk = poly_valid(STA0, STA1) && (DATW >= STA0);

    prbs_state_e     fsm_q;
    logic [STA0-1:0] st_q;
    logic [GW-1:0]   good_q;
    logic [BW-1:0]   bad_q;

    logic [STA0-1:0] gen_nxt;
    logic [DATW-1:0] gen_dat;
    logic [DATW-1:0] diff;
    logic [STA0-1:0] seed;
    logic            seed_zero;
    logic [NBW-1:0]  nbit;
    logic            chk;
    logic [GW-1:0]   good_inc;
    logic [BW-1:0]   bad_inc;
    logic [SumW-1:0] sum;
    logic [ERRW-1:0] cnt_sat;

    prbs_itu_o150 #(
        .DATW (DATW),
        .STA0 (STA0),
        .STA1 (STA1)
    ) u_gen (
        .iprbs_cur (st_q),
        .oprbs_nxt (gen_nxt),
        .oprbs_dat (gen_dat)
    );

    always_comb begin
        diff      = idat ^ gen_dat;
        seed      = idat[STA0-1:0];
        seed_zero = (seed == '0);
        nbit      = NBW'(popcount(PopMaxW'(diff)));
        chk       = ivld && (fsm_q == StLock);
        good_inc  = good_q + 1'b1;
        bad_inc   = bad_q + 1'b1;
        sum       = SumW'(oerr_cnt) + SumW'(nbit);
        // Any carry into the upper bits means the counter would wrap: pin it at all-ones.
        cnt_sat   = (sum[SumW-1:ERRW] != '0) ? '1 : sum[ERRW-1:0];
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            fsm_q     <= StHunt;
            st_q      <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            olock     <= 1'b0;
            oerr      <= 1'b0;
            oerr_nbit <= '0;
            oerr_cnt  <= '0;
        end else begin
            oerr <= 1'b0;
            if (iclr) begin
                oerr_cnt <= chk ? ERRW'(nbit) : '0;
            end else if (chk) begin
                oerr_cnt <= cnt_sat;
            end
            if (ivld) begin
                unique case (fsm_q)
                    StHunt: begin
                        if (!seed_zero) begin
                            st_q   <= seed;
                            good_q <= '0;
                            fsm_q  <= StVerify;
                        end
                    end
                    StVerify: begin
                        if (diff == '0) begin
                            st_q <= gen_nxt;
                            if (good_inc == GW'(LOCK_CNT)) begin
                                fsm_q  <= StLock;
                                olock  <= 1'b1;
                                good_q <= '0;
                                bad_q  <= '0;
                            end else begin
                                good_q <= good_inc;
                            end
                        end else begin
                            st_q   <= seed;
                            good_q <= '0;
                            if (seed_zero) begin
                                fsm_q <= StHunt;
                            end
                        end
                    end
                    StLock: begin
                        // Free-run from the local generator so line errors never reseed it.
                        st_q      <= gen_nxt;
                        oerr_nbit <= nbit;
                        oerr      <= (nbit != '0);
                        if (nbit != '0) begin
                            if (bad_inc == BW'(LOSS_CNT)) begin
                                fsm_q <= StHunt;
                                olock <= 1'b0;
                                bad_q <= '0;
                            end else begin
                                bad_q <= bad_inc;
                            end
                        end else begin
                            bad_q <= '0;
                        end
                    end
                    default: begin
                        fsm_q <= StHunt;
                        olock <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge iclk) begin
        param_check : assert (ParamOk);
    end

endmodule

// File: doc/prbs_chk_o150.md
PRBS_CHK_O150 -- requirements
Module: prbs_chk_o150

Interface
REQ-001 The block SHALL have parameter DATW, default 64: data word width; DATW >= STA0 required.
REQ-002 The block SHALL have parameter STA0, default 9: LFSR length (9/11/15/20/23/29/31).
REQ-003 The block SHALL have parameter STA1, default 5: feedback tap (5/9/14/3 or 17/18/27/28).
REQ-004 The block SHALL have parameter LOCK_CNT, default 4: consecutive error-free words needed to lock.
REQ-005 The block SHALL have parameter LOSS_CNT, default 4: consecutive errored words that drop lock.
REQ-006 The block SHALL have parameter ERRW, default 32: error counter width.
REQ-007 The block SHALL have ports:
- iclk  in  1  clock; single clock domain.
- irst  in  1  reset; synchronous, active-high.
- ivld  in  1  idat valid qualifier.
- idat  in  DATW  received word; idat[DATW-1] is the oldest bit.
- iclr  in  1  synchronous clear of oerr_cnt.
- olock  out  1  pattern lock indicator.
- oerr  out  1  one-cycle pulse: last locked word contained errors.
- oerr_nbit  out  $clog2(DATW+1)  bit errors in the last locked word.
- oerr_cnt  out  ERRW  accumulated bit errors, saturating.

Function
REQ-008 Bit ordering SHALL match the ITU O.150 parallel generator: a new bit equals s[STA0-1]^s[STA1-1]; the state shifts left with the new bit inserted at the LSB; the word is emitted MSB first.
REQ-009 The block SHALL hold a STA0-bit expected-state register; after a word it equals idat[STA0-1:0] when seeding, or the generator's next state otherwise.
REQ-010 The FSM SHALL have states HUNT, VERIFY and LOCK; it SHALL advance only on cycles with ivld=1, and all state SHALL be held while ivld=0.
REQ-011 In HUNT, with ivld, the block SHALL seed state from idat[STA0-1:0] and go to VERIFY with good count 0; an all-zero seed SHALL be rejected, leaving the FSM in HUNT.
REQ-012 In VERIFY, a word equal to the expected word SHALL increment the good count; on reaching LOCK_CNT the FSM SHALL go to LOCK.
REQ-013 In VERIFY, a mismatching word SHALL reseed from that word and clear the good count; an all-zero reseed SHALL return the FSM to HUNT.
REQ-014 In LOCK, the expected state SHALL advance from the generator only, never from idat, so errors do not propagate.
REQ-015 In LOCK, each word SHALL set oerr_nbit = popcount(idat ^ expected) and SHALL set oerr=1 if the count is nonzero.
REQ-016 In LOCK, an errored word SHALL increment the bad count; an error-free word SHALL clear it; on reaching LOSS_CNT the FSM SHALL go to HUNT.
REQ-017 oerr_cnt SHALL accumulate oerr_nbit only for words checked in LOCK, and SHALL saturate at all-ones without wrap.
REQ-018 iclr SHALL take precedence: oerr_cnt becomes that cycle's oerr_nbit (0 if none).
REQ-019 All outputs SHALL be registered, with latency 1 cycle from the ivld word.
REQ-020 oerr SHALL be 0 on any cycle not following a locked valid word.
REQ-021 olock SHALL be 1 exactly while the FSM is in LOCK.

Reset
REQ-022 On irst=1 at a clock edge, the block SHALL set: FSM=HUNT; expected state, good count and bad count = 0; olock=0, oerr=0, oerr_nbit=0, oerr_cnt=0.
REQ-023 irst SHALL override ivld and iclr; a word in flight at reset SHALL be discarded.

Structure
REQ-024 Package prbs_pkg SHALL hold: the FSM state enum typedef; the O.150 polynomial (STA0, STA1) constant table; and a popcount function.
REQ-025 The expected-word/next-state logic SHALL be one instance of the existing combinational parallel generator prbs_itu_o150 (iprbs_cur -> oprbs_nxt, oprbs_dat) with identical DATW, STA0 and STA1.

Verification
REQ-026 Clean-lock scenario: PRBS9, DATW=64, seed 9'h1FF, continuous ivld -> olock=1 in the cycle after word 5, and oerr_cnt stays 0.
REQ-027 Single-error scenario: while locked, flip idat[10] in one word -> oerr=1 for one cycle, oerr_nbit=1, oerr_cnt=1, olock stays 1, and the next clean word gives oerr=0.
REQ-028 Loss-of-lock scenario: flip 3 bits in each of 4 consecutive words -> oerr_cnt=12 and olock=0 after word 4; clean data then relocks after 5 words.
REQ-029 All-zero scenario: 100 words of 0 -> olock never asserts, and oerr_cnt=0.
REQ-030 Clear scenario: iclr is asserted with a 2-error locked word while oerr_cnt=7 -> oerr_cnt=2.
REQ-031 Reset/gap scenario: irst pulsed mid-LOCK -> next cycle all outputs are 0; with ivld toggled 1/0, relock takes 5 valid words.
REQ-032 Saturation scenario: ERRW=4, and 20 single-error words are applied -> oerr_cnt=15.
